// File: rtl/gf180mcu_fd_sc_mcu7t5v0__deser_4.sv
// Serial-to-parallel deserializer with ready/valid handshakes on both sides.
// Bits arrive LSB first. Each word is held on Q until QR accepts it.
// ERR is a sticky framing error: it is raised when SOF cuts a partial word short.
module gf180mcu_fd_sc_mcu7t5v0__deser_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D,
  input  logic             DV,
  input  logic             SOF,
  output logic             DR,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  input  logic             QR,
  output logic             ERR,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_qv;
  logic             r_err;

  logic w_dr;
  logic w_accept;
  logic w_complete;
  logic w_supply_unused;

  // The supply pins have no functional effect.
  assign w_supply_unused = VDD ^ VSS;

  // Ready depends on registers only: stall while a word is still held and
  // the next bit would complete another one.
  assign w_dr       = !(r_qv && (r_cnt == LAST));
  assign w_accept   = DV && w_dr;
  assign w_complete = w_accept && !SOF && (r_cnt == LAST);

  assign DR  = w_dr;
  assign Q   = r_q;
  assign QV  = r_qv;
  assign ERR = r_err;

  // Shift register: store accepted bits at the current bit position.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sr <= '0;
    end else if (w_accept) begin
      if (SOF) begin
        r_sr[0] <= D;
      end else begin
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
          if (r_cnt == CW'(i)) r_sr[i] <= D;
        end
      end
    end
  end

  // Bit counter: SOF restarts at 1, completion wraps to 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (SOF)             r_cnt <= CW'(1);
      else if (w_complete) r_cnt <= '0;
      else                 r_cnt <= r_cnt + CW'(1);
    end
  end

  // Output word and valid. Completion can only happen with QV low (DR gates
  // it), so the transfer clear and the completion set never collide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q  <= '0;
      r_qv <= 1'b0;
    end else begin
      if (r_qv && QR) r_qv <= 1'b0;
      if (w_complete) begin
        r_q  <= {D, r_sr};
        r_qv <= 1'b1;
      end
    end
  end

  // Sticky framing error: SOF arriving mid-word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_accept && SOF && (r_cnt != '0)) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__deser_4.md
Name: gf180mcu_fd_sc_mcu7t5v0__deser_4

Overview:
Serial-to-parallel deserializer with ready/valid handshakes on both sides. It collects single-bit serial data, LSB first, into WIDTH-bit words. Each word is presented on a registered output until the consumer accepts it. It is the splitting counterpart to the library's combining gates: one serial stream in, one parallel word out. It is used as a test/characterisation helper macro inside the 7-track 5 V cell library deliverables.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
D  input  1  serial data bit
DV  input  1  D valid
SOF  input  1  start-of-frame marker; qualified by DV
DR  output  1  ready to accept a serial bit
Q  output  WIDTH  assembled word; Q[0] is the first bit received
QV  output  1  Q valid
QR  input  1  consumer ready
ERR  output  1  sticky framing error
VDD  inout  1  supply; no functional effect
VSS  inout  1  ground; no functional effect

Behaviour:
- One clock (CLK). RST is synchronous and active-high, sampled on the CLK rising edge only.
- Internal state: shift register SR[WIDTH-2:0] and bit counter cnt (0..WIDTH-1, width clog2(WIDTH)).
- Reset values: SR=0, cnt=0, Q=0, QV=0, ERR=0, which makes DR=1. Reset overrides every other event in the same cycle.
- Reset during a partial word or a held word discards both; no QV pulse is produced.
- Accept: a bit is accepted on an edge where DV=1 and DR=1. While DR=0, D, DV and SOF are ignored and all state holds.
- DR = !(QV && cnt==WIDTH-1). DR is a function of registers only; there is no combinational path from any input to DR.
- Accepted bit, SOF=0, cnt<WIDTH-1: SR[cnt] <= D; cnt <= cnt+1.
- Accepted bit, SOF=0, cnt==WIDTH-1 (word completion):
  - Q <= {D, SR[WIDTH-2:0]}; QV <= 1; cnt <= 0.
  - QV is high on the cycle after the last bit edge (1-cycle latency).
  - Completion only occurs with QV=0, because DR is low otherwise.
- Accepted bit, SOF=1: the bit is bit 0 of a new word. SR[0] <= D; cnt <= 1.
  - If cnt!=0 at that edge: the partial word is discarded and ERR <= 1.
  - If cnt==0: normal; ERR is unchanged.
  - SOF on a word-completion slot (cnt==WIDTH-1) restarts the word; no completion occurs.
- ERR is sticky and is cleared only by RST.
- Output handshake: an edge with QV=1 and QR=1 transfers the word; QV <= 0 the next cycle.
  - Q holds its value after transfer until the next completion.
  - Q is stable while QV=1 and QR=0.
- Transfer and completion never coincide. An edge with QV=1, QR=1 and cnt==WIDTH-1 transfers the word; the pending last bit is accepted no earlier than the following edge.
- Throughput: with QR held at 1, DR never deasserts, giving one bit per cycle sustained.
- QR is ignored when QV=0.
- Other sources of invalidity: X on D while DV=0 must not propagate to Q or SR.

Test Plan:
- WIDTH=4, after reset, QR=1, DV=1 with D=1,0,1,1 on 4 consecutive edges (SOF=1 on the first) -> QV=1 the next cycle, Q=4'hD, ERR=0; QV=0 one cycle later.
- Backpressure, QR=0: word A D=0,1,0,1 gives Q=4'hA, QV=1. Stream D=1,1,1 -> DR=0 once cnt=3 and Q stays 4'hA. Raise QR for 1 cycle -> QV=0 and DR=1 next cycle. 4th bit D=0 -> Q=4'h7.
- Framing: 2 bits accepted, then DV=1, SOF=1, D=1, then D=0,0,1 -> ERR=1 from the SOF edge onward; Q=4'h9. ERR stays 1 across later words until RST.
- DV gaps: bits 1,1,0,0 interleaved with DV=0 cycles carrying D=1/X -> Q=4'h3; SR and Q are unaffected on DV=0 cycles.
- Reset mid-operation: QV=1 holding 4'hF and cnt=2, assert RST for 1 cycle -> Q=0, QV=0, ERR=0, DR=1. Next 4 bits 0,0,0,1 -> Q=4'h8.
- Streaming: QR=1, DV=1 continuously for 12 bits -> DR=1 throughout; 3 QV pulses spaced 4 cycles apart with the correct words. Repeat with WIDTH=8 and WIDTH=2.
